// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave bus arbiter for a MIPS-style memory bus.
// Requests are arbitrated in IDLE (round-robin on ties), the winner owns the
// slave in OWN, and reads return through a single-cycle RESP state.
module mips_bus_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [31:0]           m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [31:0]           s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   g, g_nxt;
  logic   lw, lw_nxt;

  logic req0, req1;
  logic rd_g, wr_g, req_g;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign rd_g  = g ? m1_read  : m0_read;
  assign wr_g  = g ? m1_write : m0_write;
  assign req_g = rd_g | wr_g;

  // Read data fans out unqualified; only readdatavalid marks it as meaningful.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  // State, grant and last-winner registers; lw=1 after reset so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      g     <= 1'b0;
      lw    <= 1'b1;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      lw    <= lw_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, complete or hold in OWN, retire reads in RESP.
  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    lw_nxt    = lw;
    unique case (state)
      IDLE: begin
        if (req0 && req1) begin
          g_nxt     = ~lw;
          state_nxt = OWN;
        end else if (req0) begin
          g_nxt     = 1'b0;
          state_nxt = OWN;
        end else if (req1) begin
          g_nxt     = 1'b1;
          state_nxt = OWN;
        end
      end
      OWN: begin
        // A master that withdraws its request forfeits the slot without
        // being credited as the last winner.
        if (!req_g) begin
          state_nxt = IDLE;
        end else if (!s_waitrequest) begin
          if (wr_g) begin
            lw_nxt    = g;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        lw_nxt    = g;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output mux: slave bus follows the granted master only in OWN; reset
  // forces the idle view so an aborted read never signals valid data.
  always_comb begin
    s_address        = '0;
    s_read           = 1'b0;
    s_write          = 1'b0;
    s_writedata      = '0;
    s_byteenable     = '0;
    m0_waitrequest   = req0;
    m1_waitrequest   = req1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    if (!reset && state == OWN) begin
      s_address    = g ? m1_address    : m0_address;
      s_writedata  = g ? m1_writedata  : m0_writedata;
      s_byteenable = g ? m1_byteenable : m0_byteenable;
      s_write      = wr_g;
      s_read       = rd_g & ~wr_g;
      if (g) m1_waitrequest = req1 & s_waitrequest;
      else   m0_waitrequest = req0 & s_waitrequest;
    end else if (!reset && state == RESP) begin
      if (g) m1_readdatavalid = 1'b1;
      else   m0_readdatavalid = 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: a table of single transfers plus
// hand-written multi-master sequences, with a per-master scoreboard checked
// by a bus monitor on the falling clock edge.
module tb_mips_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;

  mips_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } sx_t;

  typedef struct {
    bit          m;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          stall;
    int          exp_cyc;
  } vec_t;

  sx_t         q0[$], q1[$];
  logic [31:0] rq0[$], rq1[$];
  int          glog[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 0;

  // Slave model: stalls each command for stall_cfg cycles, returns data one cycle after a read.
  int stall_cfg = 0;
  int stall_seen = 0;
  assign s_waitrequest = (s_read | s_write) && (stall_seen < stall_cfg);

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h3C08_BFC0 : (a ^ 32'h5A5A_0F0F);
  endfunction

  always @(posedge clk) begin
    if (reset || !(s_read | s_write) || !s_waitrequest) stall_seen <= 0;
    else stall_seen <= stall_seen + 1;
    s_readdata <= (s_read && !s_waitrequest) ? slave_data(s_address) : 32'h0BAD_0BAD;
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus monitor: invariants every cycle, scoreboard pops on accepted commands and read returns.
  sx_t         me;
  bit          n0, n1;
  bit          pv_stall = 0;
  logic [69:0] pv_cmd;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("readdata_fanout", (m0_readdata === s_readdata) && (m1_readdata === s_readdata), 1);
      if (!(m0_read | m0_write)) chk("idle_wait_m0", m0_waitrequest, 0);
      if (!(m1_read | m1_write)) chk("idle_wait_m1", m1_waitrequest, 0);
      chk("rdv_onehot", m0_readdatavalid & m1_readdatavalid, 0);
      if (s_read | s_write) begin
        if (s_waitrequest) begin
          if (pv_stall)
            chk("stall_hold", {s_write, s_read, s_address, s_byteenable, s_writedata}, pv_cmd);
          pv_stall = 1;
          pv_cmd   = {s_write, s_read, s_address, s_byteenable, s_writedata};
        end else begin
          pv_stall = 0;
          n0 = (m0_read | m0_write) & ~m0_waitrequest;
          n1 = (m1_read | m1_write) & ~m1_waitrequest;
          chk("grant_owner", n0 ^ n1, 1);
          if (n0 ^ n1) begin
            glog.push_back(n1 ? 1 : 0);
            chk("cmd_expected", n1 ? (q1.size() != 0) : (q0.size() != 0), 1);
            if (n1 ? (q1.size() != 0) : (q0.size() != 0)) begin
              me = n1 ? q1.pop_front() : q0.pop_front();
              chk("slave_cmd",
                  {s_write, s_read, s_address, s_byteenable, me.wr ? s_writedata : 32'h0},
                  {me.wr, ~me.wr, me.a, me.be, me.wr ? me.d : 32'h0});
            end
          end
        end
      end else begin
        pv_stall = 0;
      end
      if (m0_readdatavalid) begin
        chk("m0_rdv_expected", rq0.size() != 0, 1);
        if (rq0.size() != 0) chk("m0_rdata", m0_readdata, rq0.pop_front());
      end
      if (m1_readdatavalid) begin
        chk("m1_rdv_expected", rq1.size() != 0, 1);
        if (rq1.size() != 0) chk("m1_rdata", m1_readdata, rq1.pop_front());
      end
    end
  end

  task automatic drive_m(input bit m, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (m == 1'b0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  // One master transfer: queue the expectation, drive, wait for acceptance; cyc counts falling edges to accept.
  task automatic xfer(input bit m, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, input bit keep, output int cyc);
    sx_t e;
    e.wr = wr; e.a = a; e.d = d; e.be = be;
    if (m) q1.push_back(e); else q0.push_back(e);
    if (!wr) begin
      if (m) rq1.push_back(slave_data(a)); else rq0.push_back(slave_data(a));
    end
    drive_m(m, rd, wr, a, d, be);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (!(m ? m1_waitrequest : m0_waitrequest)) break;
      if (cyc >= 64) begin
        chk("xfer_timeout", cyc, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) drive_m(m, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive_m(1, 0, 0, 32'h0, 32'h0, 4'h0);
    stall_cfg = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    glog.delete();
  endtask

  task automatic drain(input string nm);
    repeat (3) @(posedge clk);
    #1;
    chk(nm, q0.size() + q1.size() + rq0.size() + rq1.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  vec_t vt[6];
  int   c, c0, c1, s_read_cnt, rdv_at;
  logic [31:0] rdv_data;

  initial begin
    vt[0] = '{m:0, rd:1, wr:0, a:32'hBFC0_0000, d:32'h0,         be:4'hF, stall:0, exp_cyc:2};
    vt[1] = '{m:1, rd:0, wr:1, a:32'h0000_1000, d:32'h1234_5678, be:4'hF, stall:0, exp_cyc:2};
    vt[2] = '{m:0, rd:0, wr:1, a:32'h8000_0004, d:32'hA5A5_A5A5, be:4'h1, stall:2, exp_cyc:4};
    vt[3] = '{m:1, rd:1, wr:0, a:32'hFFFF_FFFC, d:32'h0,         be:4'hC, stall:1, exp_cyc:3};
    vt[4] = '{m:1, rd:1, wr:1, a:32'h0000_0010, d:32'hCAFE_F00D, be:4'h6, stall:0, exp_cyc:2};
    vt[5] = '{m:0, rd:0, wr:1, a:32'h0000_0000, d:32'h0000_0000, be:4'h0, stall:0, exp_cyc:2};

    // Reset view: s_* idle, no valid, waitrequest mirrors req.
    reset = 1'b1;
    drive_m(0, 1, 0, 32'h1234_0000, 32'h0, 4'hF);
    drive_m(1, 0, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    chk("reset_s_bus", {s_read, s_write, s_address, s_writedata, s_byteenable}, 0);
    chk("reset_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    chk("reset_wait", {m0_waitrequest, m1_waitrequest}, 2'b10);
    do_reset();
    mon_en = 1;

    // Boot fetch: s_read for one cycle, data valid on the third cycle.
    q0.push_back('{wr:0, a:32'hBFC0_0000, d:32'h0, be:4'hF});
    rq0.push_back(32'h3C08_BFC0);
    drive_m(0, 1, 0, 32'hBFC0_0000, 32'h0, 4'hF);
    s_read_cnt = 0; rdv_at = 0; rdv_data = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (s_read) s_read_cnt++;
      if (m0_readdatavalid && rdv_at == 0) begin
        rdv_at = k;
        rdv_data = m0_readdata;
      end
      if (m0_read && !m0_waitrequest) begin
        @(posedge clk);
        #1;
        drive_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
      end
    end
    chk("boot_sread_cycles", s_read_cnt, 1);
    chk("boot_rdv_cycle", rdv_at, 3);
    chk("boot_rdata", rdv_data, 32'h3C08_BFC0);
    drain("boot_drain");

    // Table of isolated transfers.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      stall_cfg = vt[i].stall;
      xfer(vt[i].m, vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].be, 0, c);
      chk($sformatf("vec%0d_latency", i), c, vt[i].exp_cyc);
      drain($sformatf("vec%0d_drain", i));
    end
    stall_cfg = 0;

    // Simultaneous writes: m0 first, m1 held until m0 completes.
    do_reset();
    fork
      xfer(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, c0);
      xfer(1, 0, 1, 32'h0000_0020, 32'h0BAD_F00D, 4'b0011, 0, c1);
    join
    chk("tie_m0_cycles", c0, 2);
    chk("tie_m1_cycles", c1, 4);
    drain("tie_drain");
    chk("tie_grant_count", glog.size(), 2);
    if (glog.size() == 2) chk("tie_grant_order", {glog[0][0], glog[1][0]}, 2'b01);

    // Continuous reads from both masters: strict alternation.
    do_reset();
    fork
      begin
        for (int k = 0; k < 4; k++) xfer(0, 1, 0, 32'h0000_0100 + k * 4, 32'h0, 4'hF, k < 3, c0);
      end
      begin
        for (int k = 0; k < 4; k++) xfer(1, 1, 0, 32'h0000_0200 + k * 4, 32'h0, 4'hF, k < 3, c1);
      end
    join
    drain("rr_drain");
    chk("rr_grant_count", glog.size(), 8);
    for (int k = 0; k < glog.size(); k++) chk($sformatf("rr_grant%0d", k), glog[k], k % 2);

    // Slave stall for 5 cycles on an m1 write while m0 waits behind it.
    do_reset();
    stall_cfg = 5;
    fork
      xfer(1, 0, 1, 32'h0000_2000, 32'hFFFF_0000, 4'hF, 0, c1);
      begin
        @(posedge clk);
        #1;
        xfer(0, 0, 1, 32'h0000_3000, 32'h1111_2222, 4'hF, 0, c0);
      end
    join
    stall_cfg = 0;
    chk("stall_m1_cycles", c1, 7);
    chk("stall_m0_cycles", c0, 13);
    drain("stall_drain");
    chk("stall_grant_count", glog.size(), 2);
    if (glog.size() == 2) chk("stall_grant_order", {glog[0][0], glog[1][0]}, 2'b10);

    // Reset during RESP aborts the read without a valid pulse.
    do_reset();
    xfer(0, 1, 0, 32'h0000_4000, 32'h0, 4'hF, 0, c);
    chk("abort_accept_cycles", c, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle_s_bus", {s_read, s_write, s_address, s_writedata, s_byteenable}, 0);
    chk("abort_pending_read", rq0.size(), 1);
    rq0.delete();
    drain("abort_drain");

    // m0 withdraws its read while granted: no slave read, m1 served next.
    do_reset();
    q1.push_back('{wr:0, a:32'h0000_5000, d:32'h0, be:4'hF});
    rq1.push_back(slave_data(32'h0000_5000));
    drive_m(0, 1, 0, 32'h0000_6000, 32'h0, 4'hF);
    drive_m(1, 1, 0, 32'h0000_5000, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    drive_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      if (!m1_waitrequest) break;
      if (c >= 20) begin
        chk("drop_timeout", c, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    drive_m(1, 0, 0, 32'h0, 32'h0, 4'h0);
    chk("drop_m1_cycles", c, 3);
    drain("drop_drain");
    chk("drop_grant_count", glog.size(), 1);
    if (glog.size() == 1) chk("drop_grant_m1", glog[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
